// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM states and datapath select codes.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_LUI      = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_ALU_WB   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JAL      = 4'd12,
    S_JALR     = 4'd13,
    S_TRAP     = 4'd14
  } ctrl_state_e;

  localparam logic [2:0] ALU_R      = 3'b000;
  localparam logic [2:0] ALU_ILOGIC = 3'b001;
  localparam logic [2:0] ALU_LUI    = 3'b010;
  localparam logic [2:0] ALU_JALR   = 3'b011;
  localparam logic [2:0] ALU_BRANCH = 3'b100;
  localparam logic [2:0] ALU_ADD    = 3'b101;
  localparam logic [2:0] ALU_SW     = 3'b110;
  localparam logic [2:0] ALU_JAL    = 3'b111;

  localparam logic [1:0] MTR_ALUOUT = 2'b00;
  localparam logic [1:0] MTR_MDR    = 2'b01;
  localparam logic [1:0] MTR_PC     = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS1   = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JALR   = 2'b10;

  // States that hold a memory strobe until Mem_Ready_i arrives.
  function automatic logic is_wait_state(input ctrl_state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Bounded memory-wait counter: clears on request, counts stalled cycles, flags when MAX_WAIT is reached.
module mc_wait_timer #(
  parameter int unsigned MAX_WAIT       = 15,
  parameter int unsigned WAIT_CNT_WIDTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [WAIT_CNT_WIDTH-1:0] MAX_CNT = WAIT_CNT_WIDTH'(MAX_WAIT);

  logic [WAIT_CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Next count: clear has priority; counting saturates so MAX_WAIT = 0 never wraps into a false match.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (MAX_WAIT != 0) && (cnt_q == MAX_CNT);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle Moore control FSM: sequences fetch/decode/execute/memory/writeback and drives datapath controls.
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT        = 15,
  parameter int unsigned WAIT_CNT_WIDTH  = 4,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] OP_i,
  input  logic       Zero_i,
  input  logic       Mem_Ready_i,
  output logic       PC_Write_o,
  output logic       PC_Write_Cond_o,
  output logic       IorD_o,
  output logic       Mem_Read_o,
  output logic       Mem_Write_o,
  output logic       IR_Write_o,
  output logic       Reg_Write_o,
  output logic [1:0] Mem_to_Reg_o,
  output logic [1:0] ALU_Src_A_o,
  output logic [1:0] ALU_Src_B_o,
  output logic [2:0] ALU_Op_o,
  output logic [1:0] PC_Src_o,
  output logic       Illegal_Op_o,
  output logic       Mem_Timeout_o,
  output logic [3:0] State_o
);

  ctrl_state_e state_q, state_d;
  logic        illegal_q, illegal_d;
  logic        timeout_q, timeout_d;
  logic        illegal_hit, timeout_hit;
  logic        expired;

  // Zero_i is consumed by the datapath together with PC_Write_Cond_o.
  logic unused_zero;
  assign unused_zero = Zero_i;

  mc_wait_timer #(
    .MAX_WAIT       (MAX_WAIT),
    .WAIT_CNT_WIDTH (WAIT_CNT_WIDTH)
  ) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (state_d != state_q),
    .enable_i  (is_wait_state(state_q) && !Mem_Ready_i),
    .expired_o (expired)
  );

  // Next-state logic; ready on the expiry cycle takes the normal exit.
  always_comb begin
    state_d     = state_q;
    illegal_hit = 1'b0;
    timeout_hit = 1'b0;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (Mem_Ready_i) begin
          state_d = S_DECODE;
        end else if (expired) begin
          state_d     = S_TRAP;
          timeout_hit = 1'b1;
        end
      end
      S_DECODE: begin
        case (OP_i)
          OP_R:               state_d = S_EXEC_R;
          OP_I:               state_d = S_EXEC_I;
          OP_LUI:             state_d = S_LUI;
          OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
          OP_BRANCH:          state_d = S_BRANCH;
          OP_JAL:             state_d = S_JAL;
          OP_JALR:            state_d = S_JALR;
          default: begin
            illegal_hit = 1'b1;
            state_d     = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I, S_LUI: state_d = S_ALU_WB;
      S_MEM_ADDR: state_d = (OP_i == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (Mem_Ready_i) begin
          state_d = S_MEM_WB;
        end else if (expired) begin
          state_d     = S_TRAP;
          timeout_hit = 1'b1;
        end
      end
      S_MEM_WR: begin
        if (Mem_Ready_i) begin
          state_d = S_FETCH;
        end else if (expired) begin
          state_d     = S_TRAP;
          timeout_hit = 1'b1;
        end
      end
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_JAL, S_JALR: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
  end

  // Flags: illegal is a one-cycle pulse unless held by TRAP; timeout only ever leads into TRAP.
  always_comb begin
    illegal_d = illegal_hit || (illegal_q && (state_q == S_TRAP));
    timeout_d = timeout_hit || timeout_q;
  end

  // State and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // Moore output decode; only FETCH's IR/PC load is gated by Mem_Ready_i.
  always_comb begin
    PC_Write_o      = 1'b0;
    PC_Write_Cond_o = 1'b0;
    IorD_o          = 1'b0;
    Mem_Read_o      = 1'b0;
    Mem_Write_o     = 1'b0;
    IR_Write_o      = 1'b0;
    Reg_Write_o     = 1'b0;
    Mem_to_Reg_o    = MTR_ALUOUT;
    ALU_Src_A_o     = SRCA_PC;
    ALU_Src_B_o     = SRCB_REG;
    ALU_Op_o        = ALU_R;
    PC_Src_o        = PCSRC_ALU;
    unique case (state_q)
      S_FETCH: begin
        Mem_Read_o  = 1'b1;
        ALU_Src_B_o = SRCB_FOUR;
        ALU_Op_o    = ALU_ADD;
        IR_Write_o  = Mem_Ready_i;
        PC_Write_o  = Mem_Ready_i;
      end
      S_DECODE: begin
        ALU_Src_A_o = SRCA_OLDPC;
        ALU_Src_B_o = SRCB_IMM;
        ALU_Op_o    = ALU_ADD;
      end
      S_EXEC_R: begin
        ALU_Src_A_o = SRCA_RS1;
        ALU_Op_o    = ALU_R;
      end
      S_EXEC_I: begin
        ALU_Src_A_o = SRCA_RS1;
        ALU_Src_B_o = SRCB_IMM;
        ALU_Op_o    = ALU_ILOGIC;
      end
      S_LUI: begin
        ALU_Src_B_o = SRCB_IMM;
        ALU_Op_o    = ALU_LUI;
      end
      S_MEM_ADDR: begin
        ALU_Src_A_o = SRCA_RS1;
        ALU_Src_B_o = SRCB_IMM;
        ALU_Op_o    = ALU_ADD;
      end
      S_MEM_RD: begin
        Mem_Read_o = 1'b1;
        IorD_o     = 1'b1;
      end
      S_MEM_WB: begin
        Reg_Write_o  = 1'b1;
        Mem_to_Reg_o = MTR_MDR;
      end
      S_MEM_WR: begin
        Mem_Write_o = 1'b1;
        IorD_o      = 1'b1;
        ALU_Op_o    = ALU_SW;
      end
      S_ALU_WB: begin
        Reg_Write_o  = 1'b1;
        Mem_to_Reg_o = MTR_ALUOUT;
      end
      S_BRANCH: begin
        ALU_Src_A_o     = SRCA_RS1;
        ALU_Op_o        = ALU_BRANCH;
        PC_Write_Cond_o = 1'b1;
        PC_Src_o        = PCSRC_ALUOUT;
      end
      S_JAL: begin
        ALU_Op_o     = ALU_JAL;
        PC_Write_o   = 1'b1;
        PC_Src_o     = PCSRC_ALUOUT;
        Reg_Write_o  = 1'b1;
        Mem_to_Reg_o = MTR_PC;
      end
      S_JALR: begin
        ALU_Src_A_o  = SRCA_RS1;
        ALU_Src_B_o  = SRCB_IMM;
        ALU_Op_o     = ALU_JALR;
        PC_Write_o   = 1'b1;
        PC_Src_o     = PCSRC_JALR;
        Reg_Write_o  = 1'b1;
        Mem_to_Reg_o = MTR_PC;
      end
      default: ;
    endcase
  end

  assign Illegal_Op_o  = illegal_q;
  assign Mem_Timeout_o = timeout_q;
  assign State_o       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: two instances (trap-on-illegal with MAX_WAIT 15, pulse-on-illegal with MAX_WAIT 3)
// checked every cycle against an instruction-path model, plus literal expectations for the key scenarios.
module tb_multicycle_control;
  import riscv_ctrl_pkg::*;

  typedef struct packed {
    logic       pcw, pcwc, iord, mrd, mwr, irw, rw;
    logic [1:0] mtr, sa, sb;
    logic [2:0] op;
    logic [1:0] pcs;
    logic       ill, tmo;
    logic [3:0] st;
  } ov_t;

  logic       clk;
  logic       reset;
  logic [6:0] OP_i;
  logic       Zero_i;
  logic       Mem_Ready_i;

  logic       pcw_a, pcwc_a, iord_a, mrd_a, mwr_a, irw_a, rw_a, ill_a, tmo_a;
  logic [1:0] mtr_a, sa_a, sb_a, pcs_a;
  logic [2:0] aluop_a;
  logic [3:0] st_a;
  logic       pcw_b, pcwc_b, iord_b, mrd_b, mwr_b, irw_b, rw_b, ill_b, tmo_b;
  logic [1:0] mtr_b, sa_b, sb_b, pcs_b;
  logic [2:0] aluop_b;
  logic [3:0] st_b;

  multicycle_control #(
    .MAX_WAIT        (15),
    .WAIT_CNT_WIDTH  (4),
    .TRAP_ON_ILLEGAL (1'b1)
  ) dut_a (
    .clk (clk), .reset (reset), .OP_i (OP_i), .Zero_i (Zero_i), .Mem_Ready_i (Mem_Ready_i),
    .PC_Write_o (pcw_a), .PC_Write_Cond_o (pcwc_a), .IorD_o (iord_a), .Mem_Read_o (mrd_a),
    .Mem_Write_o (mwr_a), .IR_Write_o (irw_a), .Reg_Write_o (rw_a), .Mem_to_Reg_o (mtr_a),
    .ALU_Src_A_o (sa_a), .ALU_Src_B_o (sb_a), .ALU_Op_o (aluop_a), .PC_Src_o (pcs_a),
    .Illegal_Op_o (ill_a), .Mem_Timeout_o (tmo_a), .State_o (st_a)
  );

  multicycle_control #(
    .MAX_WAIT        (3),
    .WAIT_CNT_WIDTH  (2),
    .TRAP_ON_ILLEGAL (1'b0)
  ) dut_b (
    .clk (clk), .reset (reset), .OP_i (OP_i), .Zero_i (Zero_i), .Mem_Ready_i (Mem_Ready_i),
    .PC_Write_o (pcw_b), .PC_Write_Cond_o (pcwc_b), .IorD_o (iord_b), .Mem_Read_o (mrd_b),
    .Mem_Write_o (mwr_b), .IR_Write_o (irw_b), .Reg_Write_o (rw_b), .Mem_to_Reg_o (mtr_b),
    .ALU_Src_A_o (sa_b), .ALU_Src_B_o (sb_b), .ALU_Op_o (aluop_b), .PC_Src_o (pcs_b),
    .Illegal_Op_o (ill_b), .Mem_Timeout_o (tmo_b), .State_o (st_b)
  );

  ov_t act_a, act_b;
  assign act_a = {pcw_a, pcwc_a, iord_a, mrd_a, mwr_a, irw_a, rw_a, mtr_a, sa_a, sb_a, aluop_a, pcs_a, ill_a, tmo_a, st_a};
  assign act_b = {pcw_b, pcwc_b, iord_b, mrd_b, mwr_b, irw_b, rw_b, mtr_b, sa_b, sb_b, aluop_b, pcs_b, ill_b, tmo_b, st_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: current step of each instance, the remaining micro-steps of the current instruction, wait count, flags.
  ctrl_state_e mst[2];
  ctrl_state_e path[2][3];
  int unsigned plen[2], pidx[2], mcnt[2];
  logic        mill[2], mtmo[2];
  logic        mvalid = 1'b0;

  function automatic ov_t exp_out(input ctrl_state_e s, input logic rdy, input logic il, input logic tm);
    ov_t o;
    o = '0;
    o.ill = il;
    o.tmo = tm;
    o.st  = s;
    case (s)
      S_FETCH:    begin o.mrd = 1; o.sb = 2'b01; o.op = 3'b101; o.irw = rdy; o.pcw = rdy; end
      S_DECODE:   begin o.sa = 2'b10; o.sb = 2'b10; o.op = 3'b101; end
      S_EXEC_R:   begin o.sa = 2'b01; o.op = 3'b000; end
      S_EXEC_I:   begin o.sa = 2'b01; o.sb = 2'b10; o.op = 3'b001; end
      S_LUI:      begin o.sb = 2'b10; o.op = 3'b010; end
      S_MEM_ADDR: begin o.sa = 2'b01; o.sb = 2'b10; o.op = 3'b101; end
      S_MEM_RD:   begin o.mrd = 1; o.iord = 1; end
      S_MEM_WB:   begin o.rw = 1; o.mtr = 2'b01; end
      S_MEM_WR:   begin o.mwr = 1; o.iord = 1; o.op = 3'b110; end
      S_ALU_WB:   begin o.rw = 1; end
      S_BRANCH:   begin o.sa = 2'b01; o.op = 3'b100; o.pcwc = 1; o.pcs = 2'b01; end
      S_JAL:      begin o.op = 3'b111; o.pcw = 1; o.pcs = 2'b01; o.rw = 1; o.mtr = 2'b10; end
      S_JALR:     begin o.sa = 2'b01; o.sb = 2'b10; o.op = 3'b011; o.pcw = 1; o.pcs = 2'b10; o.rw = 1; o.mtr = 2'b10; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic set_path(input int k, input ctrl_state_e s0, input ctrl_state_e s1, input ctrl_state_e s2, input int unsigned n);
    path[k][0] = s0;
    path[k][1] = s1;
    path[k][2] = s2;
    plen[k]    = n;
  endtask

  // Advance the model of instance k by one clock using the inputs it sees at that edge.
  task automatic model_update(input int k, input int unsigned maxw, input bit trap_ill);
    ctrl_state_e cur, nxt;
    logic        waiting;
    cur = mst[k];
    nxt = cur;
    if (reset) begin
      mst[k] = S_IDLE; mcnt[k] = 0; mill[k] = 0; mtmo[k] = 0; plen[k] = 0; pidx[k] = 0;
      mvalid = 1'b1;
    end else begin
      if (cur != S_TRAP) mill[k] = 0;
      waiting = (cur == S_FETCH || cur == S_MEM_RD || cur == S_MEM_WR) && !Mem_Ready_i;
      if (cur == S_IDLE) begin
        nxt = S_FETCH;
      end else if (cur == S_TRAP) begin
        nxt = S_TRAP;
      end else if (cur == S_DECODE) begin
        plen[k] = 0;
        case (OP_i)
          7'h33: set_path(k, S_EXEC_R, S_ALU_WB, S_IDLE, 2);
          7'h13: set_path(k, S_EXEC_I, S_ALU_WB, S_IDLE, 2);
          7'h37: set_path(k, S_LUI, S_ALU_WB, S_IDLE, 2);
          7'h03: set_path(k, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, 3);
          7'h23: set_path(k, S_MEM_ADDR, S_MEM_WR, S_IDLE, 2);
          7'h63: set_path(k, S_BRANCH, S_IDLE, S_IDLE, 1);
          7'h6F: set_path(k, S_JAL, S_IDLE, S_IDLE, 1);
          7'h67: set_path(k, S_JALR, S_IDLE, S_IDLE, 1);
          default: begin
            mill[k] = 1;
            nxt = trap_ill ? S_TRAP : S_FETCH;
          end
        endcase
        if (plen[k] > 0) begin
          nxt = path[k][0];
          pidx[k] = 1;
        end
      end else if (waiting) begin
        if (maxw != 0 && mcnt[k] == maxw) begin
          nxt = S_TRAP;
          mtmo[k] = 1;
        end else begin
          mcnt[k]++;
        end
      end else if (cur == S_FETCH) begin
        nxt = S_DECODE;
      end else if (pidx[k] < plen[k]) begin
        nxt = path[k][pidx[k]];
        pidx[k]++;
      end else begin
        nxt = S_FETCH;
      end
      if (nxt != cur) mcnt[k] = 0;
      mst[k] = nxt;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    if (mvalid) begin
      check("cycle_a", 32'(act_a), 32'(exp_out(mst[0], Mem_Ready_i, mill[0], mtmo[0])));
      check("cycle_b", 32'(act_b), 32'(exp_out(mst[1], Mem_Ready_i, mill[1], mtmo[1])));
    end
  endtask

  // One clock: models follow the edge, then the next inputs are applied and all outputs compared.
  task automatic step(input logic r, input logic rdy, input logic [6:0] op);
    @(posedge clk);
    model_update(0, 15, 1'b1);
    model_update(1, 3, 1'b0);
    @(negedge clk);
    reset       = r;
    Mem_Ready_i = rdy;
    OP_i        = op;
    Zero_i      = 1'($urandom_range(0, 1));
    #1;
    compare_all();
  endtask

  logic [6:0] legal_ops[8] = '{7'h33, 7'h13, 7'h37, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67};

  initial begin
    int         cnt;
    logic [6:0] op;
    logic       rst, rdy;
    reset = 1'b1; Mem_Ready_i = 1'b1; OP_i = 7'h33; Zero_i = 1'b0;

    // Three reset cycles, then an R-type instruction with memory always ready.
    step(1, 1, 7'h33);
    step(1, 1, 7'h33);
    step(0, 1, 7'h33);
    check("idle_state", 32'(st_a), 32'(S_IDLE));
    check("idle_outputs", 32'({act_a} >> 4), 32'h0);
    step(0, 1, 7'h33);
    check("fetch_strobes", {29'd0, mrd_a, irw_a, pcw_a}, 32'h7);
    step(0, 1, 7'h33);
    step(0, 1, 7'h33);
    check("execr_state", 32'(st_a), 32'(S_EXEC_R));
    check("execr_aluop", 32'(aluop_a), 32'h0);
    step(0, 1, 7'h33);
    check("aluwb_regwrite", {31'd0, rw_a}, 32'h1);
    step(0, 1, 7'h03);
    check("back_to_fetch", 32'(st_a), 32'(S_FETCH));

    // LW with five stalled MEM_RD cycles.
    step(0, 1, 7'h03);
    step(0, 1, 7'h03);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 7'h03);
      if (mrd_a && iord_a) cnt++;
    end
    step(0, 1, 7'h03);
    if (mrd_a && iord_a) cnt++;
    check("lw_read_held", 32'(cnt), 32'd6);
    step(0, 0, 7'h03);
    check("memwb_select", {29'd0, rw_a, mtr_a}, 32'h5);

    // Fetch that never completes: TRAP after the 16th FETCH cycle.
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 7'h33);
      if (st_a == S_FETCH) cnt++;
    end
    check("fetch_wait_cycles", 32'(cnt), 32'd16);
    step(0, 0, 7'h33);
    check("timeout_trap", {27'd0, tmo_a, st_a}, {27'd0, 1'b1, S_TRAP});

    // Ready arriving on the 16th FETCH cycle wins over the timeout.
    step(1, 0, 7'h33);
    step(0, 0, 7'h33);
    for (int i = 0; i < 15; i++) step(0, 0, 7'h33);
    step(0, 1, 7'h33);
    check("ready_16th_fetch", 32'(st_a), 32'(S_FETCH));
    step(0, 1, 7'h33);
    check("ready_16th_decode", {27'd0, tmo_a, st_a}, {27'd0, 1'b0, S_DECODE});

    // Illegal opcode: instance a traps with a sticky flag, instance b pulses and refetches.
    step(1, 1, 7'h7F);
    step(0, 1, 7'h7F);
    step(0, 1, 7'h7F);
    step(0, 1, 7'h7F);
    step(0, 1, 7'h7F);
    check("illegal_trap_a", {27'd0, ill_a, st_a}, {27'd0, 1'b1, S_TRAP});
    check("illegal_pulse_b", {27'd0, ill_b, st_b}, {27'd0, 1'b1, S_FETCH});
    step(0, 0, 7'h7F);
    check("illegal_sticky_a", {31'd0, ill_a}, 32'h1);
    check("illegal_pulse_end_b", {31'd0, ill_b}, 32'h0);

    // JALR then BRANCH.
    step(1, 1, 7'h67);
    step(0, 1, 7'h67);
    step(0, 1, 7'h67);
    step(0, 1, 7'h67);
    step(0, 1, 7'h63);
    check("jalr_controls", {22'd0, pcs_a, pcw_a, rw_a, mtr_a, aluop_a}, {22'd0, 2'b10, 1'b1, 1'b1, 2'b10, 3'b011});
    step(0, 1, 7'h63);
    step(0, 1, 7'h63);
    step(0, 1, 7'h23);
    check("branch_controls", {27'd0, pcw_a, pcwc_a, rw_a, mrd_a, mwr_a}, 32'h08);

    // Reset in the middle of a stalled store.
    step(0, 1, 7'h23);
    step(0, 1, 7'h23);
    step(0, 0, 7'h23);
    step(0, 0, 7'h23);
    step(0, 0, 7'h23);
    check("memwr_strobe", {31'd0, mwr_a}, 32'h1);
    step(1, 0, 7'h23);
    step(0, 1, 7'h33);
    check("reset_mid_store", {25'd0, mwr_a, ill_a, tmo_a, st_a}, {25'd0, 3'b000, S_IDLE});
    step(0, 1, 7'h33);
    check("fetch_after_reset", {27'd0, mrd_a, st_a}, {27'd0, 1'b1, S_FETCH});

    // Randomized traffic; opcodes only change between instructions.
    op = 7'h33;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) < 2) || (mst[0] == S_TRAP && mst[1] == S_TRAP);
      rdy = ($urandom_range(0, 99) < 70);
      if ((mst[0] == S_IDLE || mst[0] == S_FETCH || mst[0] == S_TRAP) &&
          (mst[1] == S_IDLE || mst[1] == S_FETCH || mst[1] == S_TRAP)) begin
        if ($urandom_range(0, 9) == 0) op = 7'($urandom_range(0, 127));
        else                            op = legal_ops[$urandom_range(0, 7)];
      end
      step(rst, rdy, op);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
